// File: rtl/lsq_dispatch_alloc.sv
// Dispatch-stage LDQ/STQ slot allocator with following-load RAM write ports.
// Optional LSQ_PARTIAL_DISPATCH_EN accepts the longest fitting lane prefix.
`ifndef DISPATCH_WIDTH
`define DISPATCH_WIDTH 4
`endif

module lsq_dispatch_alloc #(
  parameter int unsigned DISPATCH_WIDTH = `DISPATCH_WIDTH,
  parameter int unsigned LDQ_DEPTH      = 16,
  parameter int unsigned LDQ_INDEX      = 4,
  parameter int unsigned STQ_DEPTH      = 16,
  parameter int unsigned STQ_INDEX      = 4,
  parameter int unsigned CNT_W          = 4,
  localparam int unsigned DW   = DISPATCH_WIDTH,
  localparam int unsigned LP   = LDQ_INDEX + 1,
  localparam int unsigned SP   = STQ_INDEX + 1,
  localparam int unsigned ID_W = (LDQ_INDEX > STQ_INDEX) ? LDQ_INDEX + 1 : STQ_INDEX + 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   dispatchValid_i,
  input  logic [DW-1:0]          ldMask_i,
  input  logic [DW-1:0]          stMask_i,
  output logic                   stall_o,
  output logic [DW*ID_W-1:0]     lsqId_o,
  output logic [DW*STQ_INDEX-1:0] flwLdAddr_o,
  output logic [DW*LP-1:0]       flwLdData_o,
  output logic [DW-1:0]          flwLdWe_o,
  input  logic [CNT_W-1:0]       commitLdCnt_i,
  input  logic [CNT_W-1:0]       commitStCnt_i,
  input  logic                   recover_i,
  input  logic [SP-1:0]          recoverStqTail_i,
  output logic [LP-1:0]          ldqCount_o,
  output logic [SP-1:0]          stqCount_o
`ifdef LSQ_PARTIAL_DISPATCH_EN
  ,
  output logic [DW-1:0]          dispatchedMask_o
`endif
);

  logic [LP-1:0] ldq_head_q, ldq_head_d, ldq_tail_q, ldq_tail_d, ldq_count_q, ldq_count_d;
  logic [SP-1:0] stq_head_q, stq_head_d, stq_tail_q, stq_tail_d, stq_count_q, stq_count_d;

  logic [DW-1:0] ld_v, st_v, lane_fit, lane_acc;
  logic [LP-1:0] ld_before [DW];
  logic [SP-1:0] st_before [DW];
  logic [LP-1:0] ld_total, ld_free, ld_alloc;
  logic [SP-1:0] st_total, st_free, st_alloc;
  logic [SP-1:0] st_id;
  logic          accept;

  // Running lane-order prefix sums; a lane fits if everything up to and including it fits.
  always_comb begin
    ld_v     = ldMask_i & {DW{dispatchValid_i}};
    st_v     = stMask_i & {DW{dispatchValid_i}};
    ld_free  = LP'(LDQ_DEPTH) - ldq_count_q;
    st_free  = SP'(STQ_DEPTH) - stq_count_q;
    ld_total = '0;
    st_total = '0;
    lane_fit = '0;
    for (int k = 0; k < DW; k++) begin
      ld_before[k] = ld_total;
      st_before[k] = st_total;
      ld_total     = ld_total + LP'(ld_v[k]);
      st_total     = st_total + SP'(st_v[k]);
      lane_fit[k]  = (ld_total <= ld_free) && (st_total <= st_free);
    end
  end

  // Fit is monotone across lanes, so ~&lane_fit equals "the whole bundle does not fit".
  always_comb begin
    stall_o  = reset & dispatchValid_i & ~(&lane_fit);
`ifdef LSQ_PARTIAL_DISPATCH_EN
    accept   = reset & dispatchValid_i & ~recover_i;
    lane_acc = lane_fit & {DW{accept}};
`else
    accept   = reset & dispatchValid_i & ~stall_o & ~recover_i;
    lane_acc = {DW{accept}};
`endif
  end

`ifdef LSQ_PARTIAL_DISPATCH_EN
  assign dispatchedMask_o = lane_acc;
`endif

  always_comb begin
    lsqId_o     = '0;
    flwLdAddr_o = '0;
    flwLdData_o = '0;
    flwLdWe_o   = '0;
    ld_alloc    = '0;
    st_alloc    = '0;
    st_id       = '0;
    for (int k = 0; k < DW; k++) begin
      if (lane_acc[k] && ld_v[k]) begin
        lsqId_o[k*ID_W +: ID_W] = ID_W'(ldq_tail_q + ld_before[k]);
        ld_alloc = ld_alloc + LP'(1);
      end
      if (lane_acc[k] && st_v[k]) begin
        st_id = stq_tail_q + st_before[k];
        lsqId_o[k*ID_W +: ID_W]          = ID_W'(st_id);
        flwLdAddr_o[k*STQ_INDEX +: STQ_INDEX] = st_id[STQ_INDEX-1:0];
        flwLdData_o[k*LP +: LP]          = ldq_tail_q + ld_before[k];
        flwLdWe_o[k]                     = 1'b1;
        st_alloc = st_alloc + SP'(1);
      end
    end
  end

  always_comb begin
    ldq_head_d  = ldq_head_q + LP'(commitLdCnt_i);
    stq_head_d  = stq_head_q + SP'(commitStCnt_i);
    ldq_tail_d  = ldq_tail_q + ld_alloc;
    stq_tail_d  = stq_tail_q + st_alloc;
    ldq_count_d = ldq_count_q + ld_alloc - LP'(commitLdCnt_i);
    stq_count_d = stq_count_q + st_alloc - SP'(commitStCnt_i);
    if (recover_i) begin
      // Every uncommitted load is speculative; the STQ keeps its committed-but-undrained stores.
      ldq_tail_d  = ldq_head_d;
      stq_tail_d  = recoverStqTail_i;
      ldq_count_d = ldq_tail_d - ldq_head_d;
      stq_count_d = stq_tail_d - stq_head_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ldq_head_q  <= '0;
      ldq_tail_q  <= '0;
      ldq_count_q <= '0;
      stq_head_q  <= '0;
      stq_tail_q  <= '0;
      stq_count_q <= '0;
    end else begin
      ldq_head_q  <= ldq_head_d;
      ldq_tail_q  <= ldq_tail_d;
      ldq_count_q <= ldq_count_d;
      stq_head_q  <= stq_head_d;
      stq_tail_q  <= stq_tail_d;
      stq_count_q <= stq_count_d;
    end
  end

  assign ldqCount_o = ldq_count_q;
  assign stqCount_o = stq_count_q;

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (reset) begin
      assert (int'(commitLdCnt_i) <= int'(ldq_count_q));
      assert (int'(commitStCnt_i) <= int'(stq_count_q));
    end
  end
`endif

endmodule
